// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, opcode/operand enums, pipeline stage records and the ALU
// datapath function for the integer execution unit.
package alu_exec_unit_pkg;

  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int DISPATCH_ADDR_WIDTH  = 3;
  localparam int ROB_ADDR_WIDTH       = 5;
  localparam int XLEN                 = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;

  typedef enum logic {
    OP_REG = 1'b0,
    OP_IMM = 1'b1
  } op_type_t;

  // Operands already resolved (regfile/bypass/immediate) when latched here.
  typedef struct packed {
    logic                            valid;
    alu_cmd_t                        alu_cmd;
    logic [XLEN-1:0]                 op_a;
    logic [XLEN-1:0]                 op_b;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
  } stage_reg_t;

  typedef struct packed {
    logic                            valid;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [XLEN-1:0]                 data;
    logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
  } wb_reg_t;

  // Unknown commands produce zero rather than an arbitrary result.
  function automatic logic [XLEN-1:0] alu_compute(input alu_cmd_t cmd,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    logic [4:0]      shamt;
    shamt = b[4:0];
    case (cmd)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << shamt;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_unit_regfile.sv
// Physical register file: flop-based, async reset to zero, combinational
// read ports, one write port per lane. Register 0 is hardwired to zero.
module phys_regfile
  import alu_exec_unit_pkg::*;
#(
  parameter int NUM_REGS = 2**PHYS_REGS_ADDR_WIDTH,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] raddr_i [NUM_RD],
  output logic [XLEN-1:0]                 rdata_o [NUM_RD],
  input  logic [NUM_WR-1:0]               we_i,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] waddr_i [NUM_WR],
  input  logic [XLEN-1:0]                 wdata_i [NUM_WR]
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Write ports; higher-numbered port wins on an address collision, p0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we_i[w] && (waddr_i[w] != '0)) begin
          regs_q[waddr_i[w]] <= wdata_i[w];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rdata_o[gi] = (raddr_i[gi] == '0) ? '0 : regs_q[raddr_i[gi]];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-lane integer execution unit: RR -> EX -> WB pipeline per lane with
// full EX/WB bypassing into RR, wakeup/writeback broadcast and ROB completion.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int NUM_PHYS_REGS = 2**PHYS_REGS_ADDR_WIDTH,
  parameter int LANES         = DISPATCH_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [LANES-1:0]                issue_valid_i,
  input  alu_cmd_t                        issue_alu_cmd_i   [LANES],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_op1_i       [LANES],
  input  op_type_t                        issue_op2_type_i  [LANES],
  input  logic [XLEN-1:0]                 issue_op2_i       [LANES],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd_i   [LANES],
  input  logic [DISPATCH_ADDR_WIDTH-1:0]  issue_bank_addr_i [LANES],
  input  logic [ROB_ADDR_WIDTH-1:0]       issue_rob_addr_i  [LANES],
  output logic [LANES-1:0]                wb_valid_o,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd_o      [LANES],
  output logic [XLEN-1:0]                 wb_data           [LANES],
  output logic [LANES-1:0]                cmpl_valid,
  output logic [DISPATCH_ADDR_WIDTH-1:0]  cmpl_bank_addr    [LANES],
  output logic [ROB_ADDR_WIDTH-1:0]       cmpl_rob_addr     [LANES]
);

  localparam int PRW = PHYS_REGS_ADDR_WIDTH;

  stage_reg_t      ex_q      [LANES];
  stage_reg_t      ex_d      [LANES];
  wb_reg_t         wb_q      [LANES];
  wb_reg_t         wb_d      [LANES];
  logic [XLEN-1:0] ex_result [LANES];
  logic [XLEN-1:0] src1_val  [LANES];
  logic [XLEN-1:0] src2_val  [LANES];

  logic [PRW-1:0]  rf_raddr  [2*LANES];
  logic [XLEN-1:0] rf_rdata  [2*LANES];
  logic [LANES-1:0] rf_we;
  logic [PRW-1:0]  rf_waddr  [LANES];
  logic [XLEN-1:0] rf_wdata  [LANES];

  phys_regfile #(
    .NUM_REGS (NUM_PHYS_REGS),
    .NUM_RD   (2*LANES),
    .NUM_WR   (LANES)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // Even read ports serve src1, odd ports serve src2 of the same lane.
    assign rf_raddr[2*gi]   = issue_op1_i[gi];
    assign rf_raddr[2*gi+1] = issue_op2_i[gi][PRW-1:0];

    assign ex_result[gi] = alu_compute(ex_q[gi].alu_cmd, ex_q[gi].op_a, ex_q[gi].op_b);

    assign rf_we[gi]    = wb_q[gi].valid;
    assign rf_waddr[gi] = wb_q[gi].phys_rd;
    assign rf_wdata[gi] = wb_q[gi].data;

    assign wb_valid_o[gi]     = wb_q[gi].valid;
    assign wb_phys_rd_o[gi]   = wb_q[gi].phys_rd;
    assign wb_data[gi]        = wb_q[gi].data;
    assign cmpl_valid[gi]     = wb_q[gi].valid;
    assign cmpl_bank_addr[gi] = wb_q[gi].bank_addr;
    assign cmpl_rob_addr[gi]  = wb_q[gi].rob_addr;
  end

  // Operand resolution: regfile, overridden by WB, overridden by EX; later lanes win within a stage.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      src1_val[l] = rf_rdata[2*l];
      src2_val[l] = rf_rdata[2*l+1];
      for (int p = 0; p < LANES; p++) begin
        if (wb_q[p].valid && (rf_raddr[2*l] != '0) && (wb_q[p].phys_rd == rf_raddr[2*l]))
          src1_val[l] = wb_q[p].data;
        if (wb_q[p].valid && (rf_raddr[2*l+1] != '0) && (wb_q[p].phys_rd == rf_raddr[2*l+1]))
          src2_val[l] = wb_q[p].data;
      end
      for (int p = 0; p < LANES; p++) begin
        if (ex_q[p].valid && (rf_raddr[2*l] != '0) && (ex_q[p].phys_rd == rf_raddr[2*l]))
          src1_val[l] = ex_result[p];
        if (ex_q[p].valid && (rf_raddr[2*l+1] != '0) && (ex_q[p].phys_rd == rf_raddr[2*l+1]))
          src2_val[l] = ex_result[p];
      end
    end
  end

  // Next-state for EX and WB stages; flush kills whatever would advance at the coming edge.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ex_d[l].valid     = issue_valid_i[l] && !flush;
      ex_d[l].alu_cmd   = issue_alu_cmd_i[l];
      ex_d[l].op_a      = src1_val[l];
      ex_d[l].op_b      = (issue_op2_type_i[l] == OP_IMM) ? issue_op2_i[l] : src2_val[l];
      ex_d[l].phys_rd   = issue_phys_rd_i[l];
      ex_d[l].bank_addr = issue_bank_addr_i[l];
      ex_d[l].rob_addr  = issue_rob_addr_i[l];

      wb_d[l].valid     = ex_q[l].valid && !flush;
      wb_d[l].phys_rd   = ex_q[l].phys_rd;
      wb_d[l].data      = ex_result[l];
      wb_d[l].bank_addr = ex_q[l].bank_addr;
      wb_d[l].rob_addr  = ex_q[l].rob_addr;
    end
  end

  // Pipeline registers; reset clears every in-flight op immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        ex_q[l] <= '0;
        wb_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        ex_q[l] <= ex_d[l];
        wb_q[l] <= wb_d[l];
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected writebacks are computed from an
// architectural register model at issue time and matched cycle-exactly.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int L = DISPATCH_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [L-1:0] issue_valid_i;
  alu_cmd_t                        issue_alu_cmd_i   [L];
  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_op1_i       [L];
  op_type_t                        issue_op2_type_i  [L];
  logic [XLEN-1:0]                 issue_op2_i       [L];
  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd_i   [L];
  logic [DISPATCH_ADDR_WIDTH-1:0]  issue_bank_addr_i [L];
  logic [ROB_ADDR_WIDTH-1:0]       issue_rob_addr_i  [L];
  logic [L-1:0]                    wb_valid_o;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd_o      [L];
  logic [XLEN-1:0]                 wb_data           [L];
  logic [L-1:0]                    cmpl_valid;
  logic [DISPATCH_ADDR_WIDTH-1:0]  cmpl_bank_addr    [L];
  logic [ROB_ADDR_WIDTH-1:0]       cmpl_rob_addr     [L];

  alu_exec_unit dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .issue_valid_i     (issue_valid_i),
    .issue_alu_cmd_i   (issue_alu_cmd_i),
    .issue_op1_i       (issue_op1_i),
    .issue_op2_type_i  (issue_op2_type_i),
    .issue_op2_i       (issue_op2_i),
    .issue_phys_rd_i   (issue_phys_rd_i),
    .issue_bank_addr_i (issue_bank_addr_i),
    .issue_rob_addr_i  (issue_rob_addr_i),
    .wb_valid_o        (wb_valid_o),
    .wb_phys_rd_o      (wb_phys_rd_o),
    .wb_data           (wb_data),
    .cmpl_valid        (cmpl_valid),
    .cmpl_bank_addr    (cmpl_bank_addr),
    .cmpl_rob_addr     (cmpl_rob_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          lane;
    logic [5:0]  rd;
    logic [31:0] data;
    logic [2:0]  bank;
    logic [4:0]  rob;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] model_rf [64];
  int          checks = 0;
  int          errors = 0;

  // Independent reference ALU (commands numbered 0..9 as ADD..AND).
  function automatic logic [31:0] ref_alu(input int cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    case (cmd)
      0: return a + b;
      1: return a + (~b) + 32'd1;
      2: return a << sh;
      3: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4: return {31'd0, (a < b)};
      5: return a ^ b;
      6: return a >> sh;
      7: begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
      8: return a | b;
      9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Writeback monitor: every lane in every cycle must match the scoreboard head or be idle.
  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < L; l++) begin
        checks++;
        if (sbq.size() > 0 && sbq[0].due == cyc && sbq[0].lane == l) begin
          mon_e = sbq.pop_front();
          if (wb_valid_o[l] !== 1'b1 || cmpl_valid[l] !== 1'b1 || wb_phys_rd_o[l] !== mon_e.rd ||
              wb_data[l] !== mon_e.data || cmpl_bank_addr[l] !== mon_e.bank || cmpl_rob_addr[l] !== mon_e.rob) begin
            errors++;
            $display("FAIL wb lane%0d cyc%0d: got v=%b cv=%b rd=%0d data=%h bank=%0d rob=%0d, expected v=1 cv=1 rd=%0d data=%h bank=%0d rob=%0d",
                     l, cyc, wb_valid_o[l], cmpl_valid[l], wb_phys_rd_o[l], wb_data[l], cmpl_bank_addr[l],
                     cmpl_rob_addr[l], mon_e.rd, mon_e.data, mon_e.bank, mon_e.rob);
          end else begin
            $display("wb lane%0d cyc%0d rd=%0d data=%h bank=%0d rob=%0d ok", l, cyc, mon_e.rd, mon_e.data, mon_e.bank, mon_e.rob);
          end
        end else if (wb_valid_o[l] !== 1'b0 || cmpl_valid[l] !== 1'b0) begin
          errors++;
          $display("FAIL idle lane%0d cyc%0d: got v=%b cv=%b rd=%0d data=%h, expected v=0 cv=0",
                   l, cyc, wb_valid_o[l], cmpl_valid[l], wb_phys_rd_o[l], wb_data[l]);
        end
      end
    end
  end

  task automatic set_lane(input int l, input int cmd, input logic [5:0] op1, input bit imm,
                          input logic [31:0] op2, input logic [5:0] rd, input logic [2:0] bank,
                          input logic [4:0] rob);
    issue_valid_i[l]     = 1'b1;
    issue_alu_cmd_i[l]   = alu_cmd_t'(cmd[3:0]);
    issue_op1_i[l]       = op1;
    issue_op2_type_i[l]  = imm ? OP_IMM : OP_REG;
    issue_op2_i[l]       = op2;
    issue_phys_rd_i[l]   = rd;
    issue_bank_addr_i[l] = bank;
    issue_rob_addr_i[l]  = rob;
  endtask

  // Hold the current issue inputs for one cycle; when push is set, record expected results.
  task automatic tick(input bit push);
    exp_t e;
    logic [31:0] a, b;
    logic [31:0] res [L];
    if (push) begin
      for (int l = 0; l < L; l++) begin
        res[l] = 32'd0;
        if (issue_valid_i[l]) begin
          a = model_rf[issue_op1_i[l]];
          b = (issue_op2_type_i[l] == OP_IMM) ? issue_op2_i[l] : model_rf[issue_op2_i[l][5:0]];
          res[l] = ref_alu(int'(issue_alu_cmd_i[l]), a, b);
          e.due = cyc + 2; e.lane = l; e.rd = issue_phys_rd_i[l]; e.data = res[l];
          e.bank = issue_bank_addr_i[l]; e.rob = issue_rob_addr_i[l];
          sbq.push_back(e);
        end
      end
      for (int l = 0; l < L; l++) begin
        if (issue_valid_i[l] && issue_phys_rd_i[l] != 6'd0) model_rf[issue_phys_rd_i[l]] = res[l];
      end
    end
    @(posedge clk);
    #1;
    issue_valid_i = '0;
    flush = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) tick(1'b0);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d pending writebacks, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wb_valid_o !== '0 || cmpl_valid !== '0) begin
      errors++;
      $display("FAIL reset valids: got wb=%b cmpl=%b, expected 0", wb_valid_o, cmpl_valid);
    end
    for (int l = 0; l < L; l++) begin
      checks++;
      if (wb_data[l] !== 32'd0 || wb_phys_rd_o[l] !== 6'd0 || cmpl_bank_addr[l] !== 3'd0 || cmpl_rob_addr[l] !== 5'd0) begin
        errors++;
        $display("FAIL reset lane%0d: got data=%h rd=%0d bank=%0d rob=%0d, expected all 0",
                 l, wb_data[l], wb_phys_rd_o[l], cmpl_bank_addr[l], cmpl_rob_addr[l]);
      end
    end
    rst = 1'b1;
    tick(1'b0);
  endtask

  task automatic test_addi;
    set_lane(0, 0, 6'd0, 1, 32'd7, 6'd5, 3'd1, 5'd3);
    tick(1'b1);
    drain("addi");
    set_lane(0, 0, 6'd5, 1, 32'd0, 6'd8, 3'd2, 5'd4);   // p5 via regfile
    tick(1'b1);
    drain("addi_read");
  endtask

  task automatic test_back_to_back;
    set_lane(0, 0, 6'd0, 1, 32'd7, 6'd9, 3'd0, 5'd5);
    tick(1'b1);
    set_lane(0, 0, 6'd9, 0, 32'd9, 6'd10, 3'd0, 5'd6);  // EX bypass, both operands
    tick(1'b1);
    drain("b2b");
    // Priority: EX producer must beat the older WB producer of the same register.
    set_lane(0, 0, 6'd0, 1, 32'd1, 6'd20, 3'd1, 5'd7);
    tick(1'b1);
    set_lane(1, 0, 6'd0, 1, 32'd2, 6'd20, 3'd1, 5'd8);
    tick(1'b1);
    set_lane(0, 0, 6'd20, 1, 32'd0, 6'd21, 3'd1, 5'd9);
    tick(1'b1);
    drain("bypass_prio");
  endtask

  task automatic test_wb_bypass;
    set_lane(0, 0, 6'd0, 1, 32'd7, 6'd15, 3'd2, 5'd10);
    tick(1'b1);
    tick(1'b0);
    set_lane(1, 1, 6'd15, 1, 32'd2, 6'd7, 3'd3, 5'd11);  // cross-lane WB bypass
    tick(1'b1);
    drain("wb_bypass");
  endtask

  task automatic test_dual;
    set_lane(0, 0, 6'd0, 1, 32'h8000_0000, 6'd16, 3'd0, 5'd12);
    set_lane(1, 0, 6'd0, 1, 32'd1, 6'd17, 3'd1, 5'd13);
    tick(1'b1);
    set_lane(0, 7, 6'd16, 1, 32'd4, 6'd18, 3'd4, 5'd14);
    set_lane(1, 4, 6'd17, 1, 32'hFFFF_FFFF, 6'd19, 3'd5, 5'd15);
    tick(1'b1);
    drain("dual");
  endtask

  task automatic test_alu_ops;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    va[0] = 32'h8000_0000; vb[0] = 32'h0000_0001;
    va[1] = 32'd7;         vb[1] = 32'hFFFF_FFF9;
    va[2] = $urandom;      vb[2] = $urandom;
    va[3] = 32'hF0F0_1234; vb[3] = 32'h0000_001F;
    for (int t = 0; t < 4; t++) begin
      set_lane(0, 0, 6'd0, 1, va[t], 6'd30, 3'd0, 5'd16);
      set_lane(1, 0, 6'd0, 1, vb[t], 6'd31, 3'd1, 5'd17);
      tick(1'b1);
      for (int c = 0; c < 11; c++) begin
        set_lane(0, (c == 10) ? 15 : c, 6'd30, 0, 32'd31, 6'd32, 3'(c), 5'(c));
        set_lane(1, (c == 10) ? 12 : c, 6'd31, 1, va[t] ^ 32'h0000_0013, 6'd33, 3'(c + 1), 5'(c + 1));
        tick(1'b1);
      end
      drain("alu_ops");
    end
  endtask

  task automatic test_flush;
    set_lane(0, 0, 6'd0, 1, 32'd99, 6'd5, 3'd0, 5'd18);
    tick(1'b0);                                           // killed in EX
    flush = 1'b1;
    set_lane(1, 0, 6'd0, 1, 32'd55, 6'd9, 3'd0, 5'd19);  // dropped at issue
    tick(1'b0);
    drain("flush");
    set_lane(0, 0, 6'd5, 1, 32'd0, 6'd41, 3'd6, 5'd20);
    set_lane(1, 0, 6'd9, 1, 32'd0, 6'd42, 3'd7, 5'd21);
    tick(1'b1);
    drain("flush_read");
  endtask

  task automatic test_p0;
    set_lane(0, 0, 6'd0, 1, 32'd9, 6'd0, 3'd2, 5'd22);
    tick(1'b1);
    set_lane(1, 0, 6'd0, 0, 32'd0, 6'd22, 3'd3, 5'd23);   // must not see bypassed 9
    tick(1'b1);
    tick(1'b0);
    set_lane(0, 8, 6'd0, 1, 32'd0, 6'd23, 3'd4, 5'd24);
    tick(1'b1);
    drain("p0");
  endtask

  task automatic test_reset_mid;
    set_lane(0, 0, 6'd0, 1, 32'd77, 6'd5, 3'd1, 5'd25);
    tick(1'b0);
    set_lane(1, 0, 6'd0, 1, 32'd88, 6'd9, 3'd1, 5'd26);
    tick(1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (wb_valid_o !== '0 || cmpl_valid !== '0 || wb_data[0] !== 32'd0 || wb_phys_rd_o[0] !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid: got wb=%b cmpl=%b data0=%h rd0=%0d, expected all 0",
               wb_valid_o, cmpl_valid, wb_data[0], wb_phys_rd_o[0]);
    end
    for (int r = 0; r < 64; r++) model_rf[r] = 32'd0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain("reset_mid");
    set_lane(0, 0, 6'd5, 1, 32'd0, 6'd40, 3'd0, 5'd27);
    set_lane(1, 0, 6'd9, 1, 32'd0, 6'd43, 3'd0, 5'd28);
    tick(1'b1);
    drain("reset_mid_read");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    issue_valid_i = '0;
    for (int l = 0; l < L; l++) begin
      issue_alu_cmd_i[l] = ALU_ADD; issue_op1_i[l] = '0; issue_op2_type_i[l] = OP_IMM;
      issue_op2_i[l] = '0; issue_phys_rd_i[l] = '0; issue_bank_addr_i[l] = '0; issue_rob_addr_i[l] = '0;
    end
    for (int r = 0; r < 64; r++) model_rf[r] = 32'd0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_wb_bypass();
    test_dual();
    test_alu_ops();
    test_flush();
    test_p0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
